// File: rtl/button_request_latch.sv
// button_request_latch
//   Synchronises and debounces 30 raw pushbuttons (12 hall, 9 per car panel).
//   Each debounced rising edge sets a sticky pending-request bit. The bit is
//   held until the controller's served-clear pulse retires it.
//   Bit packing inside the block: [11:0] hall, [20:12] car 1, [29:21] car 2.
//   Optional build macro: CANCEL_EN. When defined, a press on an already
//   pending car-panel bit cancels that request. Hall bits stay set-only.
module button_request_latch #(
  parameter int CLK_PER_SAMPLE   = 2000000,
  parameter int DEBOUNCE_SAMPLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] rawFloorButton,
  input  logic [8:0]  rawInternalButton1,
  input  logic [8:0]  rawInternalButton2,
  input  logic [11:0] clrFloorButton,
  input  logic [8:0]  clrInternalButton1,
  input  logic [8:0]  clrInternalButton2,
  output logic [11:0] realFloorButton,
  output logic [8:0]  realInternalButton1,
  output logic [8:0]  realInternalButton2,
  output logic        anyRequest
);

  localparam int HALL_W = 12;
  localparam int NB     = 30;
  localparam int DS     = DEBOUNCE_SAMPLES;
  localparam int CW     = (CLK_PER_SAMPLE > 2) ? $clog2(CLK_PER_SAMPLE) : 1;

  logic [NB-1:0]         raw_w;
  logic [NB-1:0]         clr_w;
  logic [NB-1:0]         sync1_q;
  logic [NB-1:0]         sync2_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic                  tick_w;
  logic [NB-1:0][DS-1:0] shr_q;
  logic [NB-1:0][DS-1:0] shr_d;
  logic [NB-1:0]         level_q;
  logic [NB-1:0]         level_d;
  logic [NB-1:0]         level_dly_q;
  logic [NB-1:0]         press_w;
  logic [NB-1:0]         req_q;
  logic [NB-1:0]         req_d;
  logic                  any_q;

  assign raw_w = {rawInternalButton2, rawInternalButton1, rawFloorButton};
  assign clr_w = {clrInternalButton2, clrInternalButton1, clrFloorButton};

  // Two-flop synchroniser on every raw button bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_w;
      sync2_q <= sync1_q;
    end
  end

  // Shared sample prescaler; tick marks the last count of each period.
  always_comb begin
    tick_w = (cnt_q == CW'(CLK_PER_SAMPLE - 1));
    cnt_d  = tick_w ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Sample history shift and debounced level: changes only on a uniform history.
  always_comb begin
    shr_d   = shr_q;
    level_d = level_q;
    if (tick_w) begin
      for (int i = 0; i < NB; i++) begin
        shr_d[i] = {shr_q[i][DS-2:0], sync2_q[i]};
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (&shr_d[i])       level_d[i] = 1'b1;
      else if (~|shr_d[i]) level_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shr_q       <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
    end else begin
      shr_q       <= shr_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
    end
  end

  // A press is a rising edge of the debounced level; holding gives one event.
  assign press_w = level_q & ~level_dly_q;

  // Request next state: press beats clear, clear beats hold.
  always_comb begin
    req_d = '0;
    req_d[HALL_W-1:0] = press_w[HALL_W-1:0] |
                        (req_q[HALL_W-1:0] & ~clr_w[HALL_W-1:0]);
`ifdef CANCEL_EN
    // Car panels toggle: a press on a pending bit cancels it, even with a clear.
    req_d[NB-1:HALL_W] = (press_w[NB-1:HALL_W] & ~req_q[NB-1:HALL_W]) |
                         (~press_w[NB-1:HALL_W] & req_q[NB-1:HALL_W] &
                          ~clr_w[NB-1:HALL_W]);
`else
    req_d[NB-1:HALL_W] = press_w[NB-1:HALL_W] |
                         (req_q[NB-1:HALL_W] & ~clr_w[NB-1:HALL_W]);
`endif
  end

  // Pending-request registers and their registered summary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q <= '0;
      any_q <= 1'b0;
    end else begin
      req_q <= req_d;
      any_q <= |req_d;
    end
  end

  assign realFloorButton     = req_q[11:0];
  assign realInternalButton1 = req_q[20:12];
  assign realInternalButton2 = req_q[29:21];
  assign anyRequest          = any_q;

endmodule

// File: tb/tb_button_request_latch.sv
// Bench for button_request_latch with CLK_PER_SAMPLE=4, DEBOUNCE_SAMPLES=3.
// Stimulus pushes expected output snapshots into a queue; a monitor pops and
// compares them on the falling clock edge.
module tb_button_request_latch;

  logic        clk;
  logic        reset;
  logic [11:0] rawFloorButton;
  logic [8:0]  rawInternalButton1;
  logic [8:0]  rawInternalButton2;
  logic [11:0] clrFloorButton;
  logic [8:0]  clrInternalButton1;
  logic [8:0]  clrInternalButton2;
  logic [11:0] realFloorButton;
  logic [8:0]  realInternalButton1;
  logic [8:0]  realInternalButton2;
  logic        anyRequest;

  button_request_latch #(
    .CLK_PER_SAMPLE  (4),
    .DEBOUNCE_SAMPLES(3)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .rawFloorButton     (rawFloorButton),
    .rawInternalButton1 (rawInternalButton1),
    .rawInternalButton2 (rawInternalButton2),
    .clrFloorButton     (clrFloorButton),
    .clrInternalButton1 (clrInternalButton1),
    .clrInternalButton2 (clrInternalButton2),
    .realFloorButton    (realFloorButton),
    .realInternalButton1(realInternalButton1),
    .realInternalButton2(realInternalButton2),
    .anyRequest         (anyRequest)
  );

  typedef struct {
    string       name;
    logic [11:0] f;
    logic [8:0]  c1;
    logic [8:0]  c2;
    logic        any;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ecnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edges since reset release; sample ticks land on edges where ecnt%4==0.
  always @(posedge clk or posedge reset) begin
    if (reset) ecnt <= 0;
    else       ecnt <= ecnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no end of test, want end of test");
    $fatal(1, "watchdog");
  end

  // Monitor: compare every pending expectation against the live outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (realFloorButton !== e.f) begin
          n_fail++;
          $display("FAIL %s realFloorButton: got %h want %h", e.name, realFloorButton, e.f);
        end
        n_checks++;
        if (realInternalButton1 !== e.c1) begin
          n_fail++;
          $display("FAIL %s realInternalButton1: got %h want %h", e.name, realInternalButton1, e.c1);
        end
        n_checks++;
        if (realInternalButton2 !== e.c2) begin
          n_fail++;
          $display("FAIL %s realInternalButton2: got %h want %h", e.name, realInternalButton2, e.c2);
        end
        n_checks++;
        if (anyRequest !== e.any) begin
          n_fail++;
          $display("FAIL %s anyRequest: got %b want %b", e.name, anyRequest, e.any);
        end
      end
    end
  end

  task automatic expect_out(input string n, input logic [11:0] f,
                            input logic [8:0] c1, input logic [8:0] c2,
                            input logic any);
    exp_t e;
    e.name = n; e.f = f; e.c1 = c1; e.c2 = c2; e.any = any;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr(input logic [11:0] f, input logic [8:0] c1, input logic [8:0] c2);
    clrFloorButton = f; clrInternalButton1 = c1; clrInternalButton2 = c2;
    step(1);
    clrFloorButton = '0; clrInternalButton1 = '0; clrInternalButton2 = '0;
  endtask

  initial begin
    reset = 1'b1;
    rawFloorButton = '0; rawInternalButton1 = '0; rawInternalButton2 = '0;
    clrFloorButton = '0; clrInternalButton1 = '0; clrInternalButton2 = '0;
    step(3);
    expect_out("reset_state", 12'h000, 9'h000, 9'h000, 1'b0);
    step(1);
    reset = 1'b0;

    // Test 1: all hall buttons held, reset mid-cycle, re-qualify after release.
    rawFloorButton = 12'hFFF;
    step(16);
    expect_out("t1_pre", 12'hFFF, 9'h000, 9'h000, 1'b1);
    step(3);
    #2 reset = 1'b1;
    #1 expect_out("t1_async_reset", 12'h000, 9'h000, 9'h000, 1'b0);
    step(2);
    expect_out("t1_in_reset", 12'h000, 9'h000, 9'h000, 1'b0);
    reset = 1'b0;
    step(4);
    expect_out("t1_requal_early", 12'h000, 9'h000, 9'h000, 1'b0);
    step(12);
    expect_out("t1_requal", 12'hFFF, 9'h000, 9'h000, 1'b1);
    rawFloorButton = 12'h000;
    step(16);
    expect_out("t1_held_after_release", 12'hFFF, 9'h000, 9'h000, 1'b1);
    pulse_clr(12'hFFF, 9'h000, 9'h000);
    expect_out("t1_cleared", 12'h000, 9'h000, 9'h000, 1'b0);

    // Test 2: 4-clock glitch gives a single sample and is rejected.
    rawInternalButton1[3] = 1'b1;
    step(4);
    rawInternalButton1[3] = 1'b0;
    step(16);
    expect_out("t2_glitch", 12'h000, 9'h000, 9'h000, 1'b0);

    // Test 3: long hold sets bit 5 once; it is sticky until cleared.
    rawFloorButton[5] = 1'b1;
    step(16);
    expect_out("t3_set", 12'h020, 9'h000, 9'h000, 1'b1);
    step(24);
    rawFloorButton[5] = 1'b0;
    step(16);
    expect_out("t3_sticky", 12'h020, 9'h000, 9'h000, 1'b1);
    pulse_clr(12'h020, 9'h000, 9'h000);
    expect_out("t3_clr", 12'h000, 9'h000, 9'h000, 1'b0);

    // Test 4: press event and clear on the same edge; press wins.
    while (ecnt % 4 != 0) step(1);
    rawInternalButton2[7] = 1'b1;
    step(12);
    expect_out("t4_before_press", 12'h000, 9'h000, 9'h000, 1'b0);
    pulse_clr(12'h000, 9'h000, 9'h080);
    expect_out("t4_press_vs_clr", 12'h000, 9'h000, 9'h080, 1'b1);
    rawInternalButton2[7] = 1'b0;
    step(16);
    pulse_clr(12'h000, 9'h000, 9'h080);
    expect_out("t4_clr", 12'h000, 9'h000, 9'h000, 1'b0);

    // Test 5: second press on a pending car bit (cancel build toggles it off).
    rawInternalButton1[2] = 1'b1;
    step(16);
    expect_out("t5_car_first", 12'h000, 9'h004, 9'h000, 1'b1);
    rawInternalButton1[2] = 1'b0;
    step(16);
    rawInternalButton1[2] = 1'b1;
    step(16);
`ifdef CANCEL_EN
    expect_out("t5_car_second", 12'h000, 9'h000, 9'h000, 1'b0);
`else
    expect_out("t5_car_second", 12'h000, 9'h004, 9'h000, 1'b1);
`endif
    rawInternalButton1[2] = 1'b0;
    step(16);
    rawFloorButton[0] = 1'b1;
    step(16);
    rawFloorButton[0] = 1'b0;
    step(16);
    rawFloorButton[0] = 1'b1;
    step(16);
`ifdef CANCEL_EN
    expect_out("t5_hall_second", 12'h001, 9'h000, 9'h000, 1'b1);
`else
    expect_out("t5_hall_second", 12'h001, 9'h004, 9'h000, 1'b1);
`endif
    rawFloorButton[0] = 1'b0;
    step(16);
    pulse_clr(12'h001, 9'h004, 9'h000);
    expect_out("t5_clr", 12'h000, 9'h000, 9'h000, 1'b0);

    // Test 6: extreme hall bits; anyRequest follows the remaining bit.
    rawFloorButton = 12'h801;
    step(16);
    expect_out("t6_both", 12'h801, 9'h000, 9'h000, 1'b1);
    rawFloorButton = 12'h000;
    step(16);
    pulse_clr(12'h001, 9'h000, 9'h000);
    expect_out("t6_clr_bit0", 12'h800, 9'h000, 9'h000, 1'b1);
    step(2);
    pulse_clr(12'h800, 9'h000, 9'h000);
    expect_out("t6_clr_bit11", 12'h000, 9'h000, 9'h000, 1'b0);
    pulse_clr(12'h800, 9'h000, 9'h000);
    expect_out("t6_clr_on_zero", 12'h000, 9'h000, 9'h000, 1'b0);

    step(3);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
